// File: rtl/xm_mem_pkg.sv
// Shared types and encodings for the memory bus controller.
package xm_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StFault
  } state_e;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_lane_steer.sv
// Combinational byte-lane steering: byte enables, write replication, read lane select.
module mem_lane_steer
  import xm_mem_pkg::*;
#(
  parameter int unsigned WORD = 16
) (
  input  logic            addr_lsb_i,
  input  logic            bw_i,
  input  logic [WORD-1:0] wdata_i,
  input  logic [WORD-1:0] rdata_i,
  output logic [1:0]      be_o,
  output logic [WORD-1:0] wdata_o,
  output logic [WORD-1:0] rdata_o
);

  always_comb begin
    be_o    = BE_WORD;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    if (bw_i) begin
      be_o         = addr_lsb_i ? BE_HI : BE_LO;
      wdata_o      = {(WORD / 8){wdata_i[7:0]}};
      rdata_o      = '0;
      rdata_o[7:0] = addr_lsb_i ? rdata_i[15:8] : rdata_i[7:0];
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: MAR/MDR requests to a 16-bit byte-enabled bus with ack handshake.
// Define MEM_TIMEOUT_EN to abort accesses that see no ack within TIMEOUT cycles.
module mem_bus_ctrl
  import xm_mem_pkg::*;
#(
  parameter int unsigned WORD    = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            req_i,
  input  logic            rw_i,
  input  logic            bw_i,
  input  logic [WORD-1:0] mar_i,
  input  logic [WORD-1:0] omdr_i,
  output logic [WORD-1:0] imdr_o,
  output logic            imdr_wr_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [WORD-1:0] mem_addr_o,
  output logic [WORD-1:0] mem_wdata_o,
  input  logic [WORD-1:0] mem_rdata_i,
  output logic            mem_rd_o,
  output logic            mem_wr_o,
  output logic [1:0]      mem_be_o,
  input  logic            mem_ack_i
);

  state_e          state_q;
  logic            addr_lsb_q, rw_q, bw_q;
  logic [WORD-1:0] omdr_q;
  logic            mem_rd_q, mem_wr_q;
  logic [WORD-1:0] mem_addr_q, mem_wdata_q, imdr_q;
  logic [1:0]      mem_be_q;
  logic            imdr_wr_q, done_q, err_q;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  logic [CntW-1:0] tmo_q;
`endif

  // In IDLE the steering sees the incoming request so bus outputs register on acceptance;
  // afterwards it sees the latched fields so read data is steered with the request's lane.
  logic            st_lsb, st_bw;
  logic [WORD-1:0] st_wdata_in;
  logic [1:0]      st_be;
  logic [WORD-1:0] st_wdata, st_rdata;

  assign st_lsb      = (state_q == StIdle) ? mar_i[0] : addr_lsb_q;
  assign st_bw       = (state_q == StIdle) ? bw_i : bw_q;
  assign st_wdata_in = (state_q == StIdle) ? omdr_i : omdr_q;

  mem_lane_steer #(
    .WORD(WORD)
  ) u_lane_steer (
    .addr_lsb_i(st_lsb),
    .bw_i      (st_bw),
    .wdata_i   (st_wdata_in),
    .rdata_i   (mem_rdata_i),
    .be_o      (st_be),
    .wdata_o   (st_wdata),
    .rdata_o   (st_rdata)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= StIdle;
      addr_lsb_q  <= 1'b0;
      rw_q        <= RW_READ;
      bw_q        <= 1'b0;
      omdr_q      <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      imdr_q      <= '0;
      imdr_wr_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      imdr_wr_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_i) begin
            addr_lsb_q <= mar_i[0];
            rw_q       <= rw_i;
            bw_q       <= bw_i;
            omdr_q     <= omdr_i;
`ifdef MEM_TIMEOUT_EN
            tmo_q      <= '0;
`endif
            if (!bw_i && mar_i[0]) begin
              state_q <= StFault;
            end else begin
              state_q     <= StAccess;
              mem_rd_q    <= (rw_i == RW_READ);
              mem_wr_q    <= (rw_i == RW_WRITE);
              mem_addr_q  <= {mar_i[WORD-1:1], 1'b0};
              mem_be_q    <= st_be;
              mem_wdata_q <= st_wdata;
            end
          end
        end
        StAccess: begin
          if (mem_ack_i) begin
            state_q     <= StIdle;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            done_q      <= 1'b0 | 1'b1;
            if (rw_q == RW_READ) begin
              imdr_q    <= st_rdata;
              imdr_wr_q <= 1'b1;
            end
`ifdef MEM_TIMEOUT_EN
          end else if (tmo_q == CntW'(TIMEOUT - 1)) begin
            state_q     <= StFault;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
`endif
          end
        end
        StFault: begin
          state_q <= StIdle;
          done_q  <= 1'b1;
          err_q   <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign imdr_o      = imdr_q;
  assign imdr_wr_o   = imdr_wr_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_be_o    = mem_be_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl; expected transactions queued at request, checked at done.
module tb_mem_bus_ctrl;
  import xm_mem_pkg::*;

  localparam int unsigned WORD    = 16;
  localparam int unsigned TIMEOUT = 15;

  logic            clk_i = 1'b0;
  logic            arst_i, req_i, rw_i, bw_i, mem_ack_i;
  logic [WORD-1:0] mar_i, omdr_i, mem_rdata_i;
  logic [WORD-1:0] imdr_o, mem_addr_o, mem_wdata_o;
  logic            imdr_wr_o, busy_o, done_o, err_o, mem_rd_o, mem_wr_o;
  logic [1:0]      mem_be_o;

  mem_bus_ctrl #(
    .WORD   (WORD),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .req_i      (req_i),
    .rw_i       (rw_i),
    .bw_i       (bw_i),
    .mar_i      (mar_i),
    .omdr_i     (omdr_i),
    .imdr_o     (imdr_o),
    .imdr_wr_o  (imdr_wr_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_rd_o   (mem_rd_o),
    .mem_wr_o   (mem_wr_o),
    .mem_be_o   (mem_be_o),
    .mem_ack_i  (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [15:0] imdr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic start_req(input logic rw, input logic bw, input logic [15:0] mar,
                           input logic [15:0] omdr, input logic [15:0] rdata);
    exp_t e;
    logic [7:0] lane;
    lane    = mar[0] ? rdata[15:8] : rdata[7:0];
    e.rw    = rw;
    e.addr  = {mar[15:1], 1'b0};
    e.be    = !bw ? 2'b11 : (mar[0] ? 2'b10 : 2'b01);
    e.wdata = bw ? {omdr[7:0], omdr[7:0]} : omdr;
    e.imdr  = bw ? {8'h00, lane} : rdata;
    sb.push_back(e);
    rw_i = rw; bw_i = bw; mar_i = mar; omdr_i = omdr; mem_rdata_i = rdata; req_i = 1'b1;
  endtask

  // Runs one normal access: ack after `waits` wait cycles, then checks completion.
  task automatic serve(input int waits, input string name);
    exp_t e;
    int   cnt;
    bit   stable;
    e = sb[0];
    @(negedge clk_i);
    req_i = 1'b0;
    n_cmp++;
    if (mem_rd_o !== (e.rw == RW_READ) || mem_wr_o !== (e.rw == RW_WRITE)) begin
      n_bad++; $display("FAIL %s strobe: rd=%b wr=%b, want rw=%b", name, mem_rd_o, mem_wr_o, e.rw);
    end
    n_cmp++;
    if (mem_addr_o !== e.addr) begin
      n_bad++; $display("FAIL %s addr: got %h want %h", name, mem_addr_o, e.addr);
    end
    n_cmp++;
    if (mem_be_o !== e.be) begin
      n_bad++; $display("FAIL %s be: got %b want %b", name, mem_be_o, e.be);
    end
    if (e.rw == RW_WRITE) begin
      n_cmp++;
      if (mem_wdata_o !== e.wdata) begin
        n_bad++; $display("FAIL %s wdata: got %h want %h", name, mem_wdata_o, e.wdata);
      end
    end
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_bad++; $display("FAIL %s busy: got %b want 1", name, busy_o);
    end
    cnt = 0;
    stable = 1'b1;
    while ((mem_rd_o || mem_wr_o) && cnt < 200) begin
      cnt++;
      if (mem_addr_o !== e.addr || mem_be_o !== e.be) stable = 1'b0;
      mem_ack_i = (cnt == waits + 1);
      @(negedge clk_i);
      mem_ack_i = 1'b0;
    end
    n_cmp++;
    if (!stable) begin
      n_bad++; $display("FAIL %s stable: bus changed while waiting, got 0 want 1", name);
    end
    n_cmp++;
    if (cnt != waits + 1) begin
      n_bad++; $display("FAIL %s strobe_cycles: got %0d want %0d", name, cnt, waits + 1);
    end
    n_cmp++;
    if (done_o !== 1'b1 || err_o !== 1'b0) begin
      n_bad++; $display("FAIL %s done/err: got %b/%b want 1/0", name, done_o, err_o);
    end
    n_cmp++;
    if (imdr_wr_o !== (e.rw == RW_READ)) begin
      n_bad++; $display("FAIL %s imdr_wr: got %b want %b", name, imdr_wr_o, e.rw == RW_READ);
    end
    if (e.rw == RW_READ) begin
      n_cmp++;
      if (imdr_o !== e.imdr) begin
        n_bad++; $display("FAIL %s imdr: got %h want %h", name, imdr_o, e.imdr);
      end
    end
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++; $display("FAIL %s busy_after: got %b want 0", name, busy_o);
    end
    void'(sb.pop_front());
  endtask

  task automatic test_reset();
    arst_i = 1'b1; req_i = 1'b0; rw_i = 1'b0; bw_i = 1'b0; mem_ack_i = 1'b0;
    mar_i = '0; omdr_i = '0; mem_rdata_i = '0;
    @(negedge clk_i);
    n_cmp++;
    if ({mem_rd_o, mem_wr_o, busy_o, done_o, err_o, imdr_wr_o} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 000000",
                        {mem_rd_o, mem_wr_o, busy_o, done_o, err_o, imdr_wr_o});
    end
    n_cmp++;
    if ({mem_addr_o, mem_wdata_o, imdr_o, mem_be_o} !== '0) begin
      n_bad++; $display("FAIL reset_data: addr=%h wdata=%h imdr=%h be=%b want 0",
                        mem_addr_o, mem_wdata_o, imdr_o, mem_be_o);
    end
    arst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_word_read();
    start_req(RW_READ, 1'b0, 16'h0100, 16'h0000, 16'hBEEF);
    serve(2, "word_read");
  endtask

  task automatic test_byte_write();
    start_req(RW_WRITE, 1'b1, 16'h0203, 16'h12A5, 16'h0000);
    serve(0, "byte_write");
  endtask

  task automatic test_byte_read();
    start_req(RW_READ, 1'b1, 16'h0011, 16'h0000, 16'h7F80);
    serve(1, "byte_read_hi");
    @(negedge clk_i);
    start_req(RW_READ, 1'b1, 16'h0010, 16'h0000, 16'h7F80);
    serve(0, "byte_read_lo");
  endtask

  task automatic test_misaligned();
    @(negedge clk_i);
    start_req(RW_READ, 1'b0, 16'h0005, 16'h0000, 16'h0000);
    @(negedge clk_i);
    req_i = 1'b0;
    n_cmp++;
    if (mem_rd_o !== 1'b0 || mem_wr_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0) begin
      n_bad++; $display("FAIL misaligned_fault: rd=%b wr=%b busy=%b done=%b want 0 0 1 0",
                        mem_rd_o, mem_wr_o, busy_o, done_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (done_o !== 1'b1 || err_o !== 1'b1 || imdr_wr_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++; $display("FAIL misaligned_done: done=%b err=%b imdr_wr=%b busy=%b want 1 1 0 0",
                        done_o, err_o, imdr_wr_o, busy_o);
    end
    void'(sb.pop_front());
    @(negedge clk_i);
    n_cmp++;
    if (done_o !== 1'b0 || err_o !== 1'b0) begin
      n_bad++; $display("FAIL misaligned_pulse: done=%b err=%b want 0 0", done_o, err_o);
    end
  endtask

  task automatic test_back_to_back();
    start_req(RW_WRITE, 1'b0, 16'h0400, 16'hC0DE, 16'h0000);
    serve(0, "b2b_first");
    start_req(RW_READ, 1'b1, 16'h0401, 16'h0000, 16'h3CA1);
    serve(3, "b2b_second");
  endtask

  task automatic test_idle_ack();
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    repeat (2) @(negedge clk_i);
    mem_ack_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || imdr_wr_o !== 1'b0 || mem_rd_o !== 1'b0) begin
      n_bad++; $display("FAIL idle_ack: busy=%b done=%b imdr_wr=%b rd=%b want 0 0 0 0",
                        busy_o, done_o, imdr_wr_o, mem_rd_o);
    end
  endtask

  task automatic test_timeout();
    int cnt;
    start_req(RW_READ, 1'b0, 16'h0040, 16'h0000, 16'h1111);
    @(negedge clk_i);
    req_i = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt = 0;
    while ((mem_rd_o || mem_wr_o) && cnt < 200) begin
      cnt++;
      @(negedge clk_i);
    end
    n_cmp++;
    if (cnt != TIMEOUT) begin
      n_bad++; $display("FAIL timeout_cycles: got %0d want %0d", cnt, TIMEOUT);
    end
    n_cmp++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      n_bad++; $display("FAIL timeout_fault: busy=%b done=%b want 1 0", busy_o, done_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (err_o !== 1'b1 || done_o !== 1'b1 || imdr_wr_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++; $display("FAIL timeout_err: err=%b done=%b imdr_wr=%b busy=%b want 1 1 0 0",
                        err_o, done_o, imdr_wr_o, busy_o);
    end
    void'(sb.pop_front());
`else
    cnt = 0;
    repeat (40) @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b1 || mem_rd_o !== 1'b1 || err_o !== 1'b0) begin
      n_bad++; $display("FAIL no_timeout_wait: busy=%b rd=%b err=%b want 1 1 0",
                        busy_o, mem_rd_o, err_o);
    end
    #2 arst_i = 1'b1;
    @(negedge clk_i);
    arst_i = 1'b0;
    sb.delete();
`endif
    @(negedge clk_i);
  endtask

  task automatic test_arst_mid_access();
    start_req(RW_READ, 1'b0, 16'h0300, 16'h0000, 16'h1234);
    @(negedge clk_i);
    req_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (mem_rd_o !== 1'b1 || busy_o !== 1'b1) begin
      n_bad++; $display("FAIL arst_pre: rd=%b busy=%b want 1 1", mem_rd_o, busy_o);
    end
    #2 arst_i = 1'b1;
    #1;
    n_cmp++;
    if (mem_rd_o !== 1'b0 || busy_o !== 1'b0 || mem_be_o !== 2'b00 || mem_addr_o !== '0) begin
      n_bad++; $display("FAIL arst_immediate: rd=%b busy=%b be=%b addr=%h want 0 0 00 0000",
                        mem_rd_o, busy_o, mem_be_o, mem_addr_o);
    end
    @(negedge clk_i);
    arst_i    = 1'b0;
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    n_cmp++;
    if (done_o !== 1'b0 || imdr_wr_o !== 1'b0 || busy_o !== 1'b0 || imdr_o !== '0) begin
      n_bad++; $display("FAIL arst_late_ack: done=%b imdr_wr=%b busy=%b imdr=%h want 0 0 0 0000",
                        done_o, imdr_wr_o, busy_o, imdr_o);
    end
    sb.delete();
    start_req(RW_READ, 1'b1, 16'h0301, 16'h0000, 16'h5AC3);
    serve(1, "after_arst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_read();
    @(negedge clk_i);
    test_byte_write();
    @(negedge clk_i);
    test_byte_read();
    test_misaligned();
    test_back_to_back();
    test_idle_ack();
    test_timeout();
    test_arst_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
